// File: rtl/conv_window_engine.sv
// Walks all POSxPOS 4x4 window positions, returns one signed kernel dot product per position.
// Latency 3 cycles from issue to res_valid, 1 result/cycle; no backpressure, every result must be taken.
module conv_window_engine #(
    parameter int IMG   = 13,
    parameter int WIN   = 4,
    parameter int OUT_W = 21,
    parameter int RELU  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       weights,
    output logic [3:0]         k,
    output logic [3:0]         q,
    input  logic [127:0]       window_in,
    output logic               res_valid,
    output logic [OUT_W-1:0]   res_data,
    output logic [6:0]         res_addr,
    output logic               busy,
    output logic               done
);

    localparam int POS  = IMG - WIN + 1;
    localparam int NPIX = WIN * WIN;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [3:0]    k_q, q_q;
    logic [1:0]    drain_q;
    logic          busy_q, done_q;
    logic [127:0]  w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            q_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        w_q     <= weights;
                        k_q     <= '0;
                        q_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // Last position keeps k/q parked; the pipeline still has 3 stages to flush.
                    if (q_q == 4'(POS - 1)) begin
                        if (k_q == 4'(POS - 1)) begin
                            drain_q <= '0;
                            state_q <= DRAIN;
                        end else begin
                            q_q <= '0;
                            k_q <= k_q + 4'd1;
                        end
                    end else begin
                        q_q <= q_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q == 2'd2) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic                issue_vld;
    logic [6:0]          issue_addr;
    logic                v1_q, v2_q, res_valid_q;
    logic [6:0]          a1_q, a2_q, res_addr_q;
    logic signed [16:0]  prod_d [NPIX];
    logic signed [16:0]  prod_q [NPIX];
    logic signed [OUT_W-1:0] sum_d, res_d, res_data_q;

    assign issue_vld  = (state_q == SCAN);
    assign issue_addr = 7'(int'(k_q) * POS + int'(q_q));

    always_comb begin
        for (int n = 0; n < NPIX; n++) begin
            logic signed [16:0] px_s, wt_s;
            px_s = {9'b0, window_in[8*n +: 8]};
            wt_s = {{9{w_q[8*n+7]}}, w_q[8*n +: 8]};
            prod_d[n] = px_s * wt_s;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int n = 0; n < NPIX; n++) begin
            sum_d = sum_d + OUT_W'(prod_q[n]);
        end
        res_d = (RELU != 0 && sum_d[OUT_W-1]) ? '0 : sum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            res_valid_q <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else begin
            v1_q        <= issue_vld;
            a1_q        <= issue_addr;
            v2_q        <= v1_q;
            a2_q        <= a1_q;
            res_valid_q <= v2_q;
            if (v2_q) begin
                res_addr_q <= a2_q;
                res_data_q <= res_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < NPIX; n++) begin
            prod_q[n] <= prod_d[n];
        end
    end

    assign k         = k_q;
    assign q         = q_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_addr  = res_addr_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_conv_window_engine.sv
// Bench for conv_window_engine: a registered buffer model feeds two instances (RELU=0 and RELU=1).
module tb_conv_window_engine;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [127:0] weights;
    logic [3:0]   dk, dq, dk_r, dq_r;
    logic [127:0] win0, win1;
    logic         res_valid, res_valid_r, busy, busy_r, done, done_r;
    logic [20:0]  res_data, res_data_r;
    logic [6:0]   res_addr, res_addr_r;

    always #5 clk = ~clk;

    conv_window_engine dut (
        .clk(clk), .rst(rst), .start(start), .weights(weights), .k(dk), .q(dq),
        .window_in(win0), .res_valid(res_valid), .res_data(res_data), .res_addr(res_addr),
        .busy(busy), .done(done)
    );

    conv_window_engine #(.RELU(1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .weights(weights), .k(dk_r), .q(dq_r),
        .window_in(win1), .res_valid(res_valid_r), .res_data(res_data_r), .res_addr(res_addr_r),
        .busy(busy_r), .done(done_r)
    );

    int nchk = 0, nfail = 0;
    int cyc = 0, s = 0, pmode = 0;
    int qa[$], qd[$], qc[$];
    int got0, got99, got0r, got99r;

    typedef struct {
        int           pm;
        logic [127:0] w;
        int           e0, e99, r0, r99;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input longint got, input longint exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc - s);
        end
    endtask

    function automatic int pix(input int r, input int c);
        case (pmode)
            0:       return 1;
            1:       return r * 13 + c;
            default: return 255;
        endcase
    endfunction

    function automatic logic [127:0] mkwin(input logic [3:0] kk, input logic [3:0] qq);
        logic [127:0] w;
        int v;
        w = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                v = pix(int'(kk) + i, int'(qq) + j);
                w[8*(4*i+j) +: 8] = v[7:0];
            end
        return w;
    endfunction

    function automatic int dot(input int kk, input int qq, input logic [127:0] w);
        int acc;
        logic signed [7:0] wb;
        acc = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wb = w[8*(4*i+j) +: 8];
                acc += pix(kk + i, qq + j) * int'(wb);
            end
        return acc;
    endfunction

    // Buffer model: k/q sampled at the edge, window valid the whole next cycle.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        win0 <= mkwin(dk, dq);
        win1 <= mkwin(dk_r, dq_r);
    end

    // Scoreboard: every result popped against the expectation pushed at the accepted start.
    always @(negedge clk) begin
        if (res_valid || res_valid_r) begin
            if (qa.size() == 0) begin
                chk("unexpected_result_addr", res_addr, -1);
            end else begin
                int ea, ed, ec;
                ea = qa.pop_front();
                ed = qd.pop_front();
                ec = qc.pop_front();
                chk("res_valid", res_valid, 1);
                chk("res_addr", res_addr, ea);
                chk("res_data", int'($signed(res_data)), ed);
                chk("res_cycle", cyc, ec);
                chk("relu_valid", res_valid_r, 1);
                chk("relu_data", int'($signed(res_data_r)), (ed < 0) ? 0 : ed);
                if (ea == 0)  begin got0  = int'($signed(res_data)); got0r  = int'($signed(res_data_r)); end
                if (ea == 99) begin got99 = int'($signed(res_data)); got99r = int'($signed(res_data_r)); end
            end
        end
    end

    // Assumes the caller is at a negedge; that cycle becomes cycle 0 of the scan.
    task automatic begin_scan(input int pm, input logic [127:0] w);
        pmode   = pm;
        weights = w;
        start   = 1'b1;
        s       = cyc;
        for (int n = 0; n < 100; n++) begin
            qa.push_back(n);
            qd.push_back(dot(n / 10, n % 10, w));
            qc.push_back(s + 4 + n);
        end
    endtask

    task automatic step_to(input int rel, input bit chk_kq);
        int r;
        while (cyc - s < rel) begin
            @(negedge clk);
            start = 1'b0;
            r = cyc - s;
            chk("busy", busy, (r >= 1 && r <= 103) ? 1 : 0);
            chk("done", done, (r == 104) ? 1 : 0);
            if (chk_kq && r >= 1 && r <= 100) begin
                chk("k_issue", dk, (r - 1) / 10);
                chk("q_issue", dq, (r - 1) % 10);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, {16{8'h01}}, 16, 16, 16, 16};
        tbl[1] = '{1, 128'h01, 0, 126, 0, 126};
        tbl[2] = '{2, {16{8'h80}}, -522240, -522240, 0, 0};

        rst = 1'b1; start = 1'b0; weights = '0;
        repeat (3) @(negedge clk);
        chk("rst_k", dk, 0);
        chk("rst_q", dq, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_relu_valid", res_valid_r, 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got0 = 12345; got99 = 12345; got0r = 12345; got99r = 12345;
            begin_scan(tbl[i].pm, tbl[i].w);
            step_to(105, tbl[i].pm == 1);
            chk("tbl_queue_empty", qa.size(), 0);
            chk("tbl_addr0", got0, tbl[i].e0);
            chk("tbl_addr99", got99, tbl[i].e99);
            chk("tbl_relu_addr0", got0r, tbl[i].r0);
            chk("tbl_relu_addr99", got99r, tbl[i].r99);
        end

        // Weights changed and start re-pulsed mid-scan must both be ignored.
        @(negedge clk);
        begin_scan(1, {$urandom, $urandom, $urandom, $urandom});
        step_to(10, 1'b1);
        weights = {$urandom, $urandom, $urandom, $urandom};
        step_to(50, 1'b1);
        start = 1'b1;
        step_to(105, 1'b1);
        chk("nostart_queue_empty", qa.size(), 0);

        // Reset in cycle 30 aborts the scan silently.
        @(negedge clk);
        begin_scan(1, {$urandom, $urandom, $urandom, $urandom});
        step_to(30, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qd.delete(); qc.delete();
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_k", dk, 0);
        chk("midrst_q", dq, 0);
        repeat (80) begin
            @(negedge clk);
            chk("midrst_done_quiet", done, 0);
        end
        begin_scan(1, {$urandom, $urandom, $urandom, $urandom});
        step_to(104, 1'b1);

        // Start in the DONE cycle is ignored; the very next cycle is accepted.
        start   = 1'b1;
        weights = {16{8'h7f}};
        @(negedge clk);
        chk("b2b_prev_queue_empty", qa.size(), 0);
        begin_scan(0, {16{8'hff}});
        step_to(105, 1'b0);
        chk("b2b_queue_empty", qa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
